wiphase_led_pwm: RTL and testbench

- Memory-mapped LED effect stage sitting directly downstream of the LED PIO.
- Consumes the PIO's 4-bit LED pattern and drives the board LED pins with per-LED 8-bit PWM brightness and optional per-LED blinking.
- Configured by the Nios/HPS through its own Avalon-MM slave. Zero-wait reads, same register style as the PIO.
- Function is gating only: a LED is lit only while its PIO bit is 1.

---
 rtl/wiphase_led_pkg.sv | 16 +
 rtl/wiphase_led_prescaler.sv | 29 ++
 rtl/wiphase_led_pwm.sv | 147 ++++++++++++++
 tb/tb_wiphase_led_pwm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wiphase_led_pkg.sv
// Shared register map and field widths for the LED PWM/blink effect stage.
package wiphase_led_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_DUTY     = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    localparam int unsigned CTRL_ENABLE_BIT = 0;

    localparam int unsigned PRESCALE_W     = 16;
    localparam int unsigned DUTY_W         = 8;
    localparam int unsigned BLINK_W        = 16;
    localparam int unsigned BLINK_MASK_LSB = 16;

endpackage

// File: rtl/wiphase_led_prescaler.sv
// PWM tick prescaler: pulses tick for one clk each time pre_cnt reaches PRESCALE.
module wiphase_led_prescaler
    import wiphase_led_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    // >= rather than == so a lowered PRESCALE ticks at once instead of wrapping
    always_comb begin
        tick = !clear && (pre_cnt >= prescale);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wiphase_led_pwm.sv
// LED PWM/blink gating stage behind the LED PIO, Avalon-MM configured.
// Blink logic is present only when WIPHASE_LED_BLINK_EN is defined.
module wiphase_led_pwm
    import wiphase_led_pkg::*;
#(
    parameter int unsigned     NUM_LEDS       = 4,
    parameter logic [15:0]     PRESCALE_RESET = 16'd49,
    parameter logic [7:0]      DUTY_RESET     = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int unsigned DUTY_BITS = NUM_LEDS * DUTY_W;

    logic                            wr_en;
    logic                            enable;
    logic [PRESCALE_W-1:0]           prescale;
    logic [NUM_LEDS-1:0][DUTY_W-1:0] duty_reg;
    logic [NUM_LEDS-1:0][DUTY_W-1:0] duty_act;
    logic [DUTY_W-1:0]               pwm_cnt;
    logic                            tick;
    logic                            period_end;
    logic [NUM_LEDS-1:0]             pwm_on;
    logic [NUM_LEDS-1:0]             blink_gate;
    logic                            unused_wdata;

    always_comb begin
        wr_en        = chipselect && !write_n;
        period_end   = tick && (pwm_cnt == '1);
        unused_wdata = ^writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b1;
            prescale <= PRESCALE_RESET;
            duty_reg <= {NUM_LEDS{DUTY_RESET}};
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL:     enable   <= writedata[CTRL_ENABLE_BIT];
                ADDR_PRESCALE: prescale <= writedata[PRESCALE_W-1:0];
                ADDR_DUTY:     duty_reg <= writedata[DUTY_BITS-1:0];
                default: ;
            endcase
        end
    end

    wiphase_led_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (!enable),
        .prescale (prescale),
        .tick     (tick)
    );

`ifdef WIPHASE_LED_BLINK_EN
    logic [BLINK_W-1:0]  blink_half;
    logic [NUM_LEDS-1:0] blink_mask;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_half <= '0;
            blink_mask <= '0;
        end else if (wr_en && address == ADDR_BLINK) begin
            blink_half <= writedata[BLINK_W-1:0];
            blink_mask <= writedata[BLINK_MASK_LSB +: NUM_LEDS];
        end
    end

    // compare sees the pre-write half_period when a write lands on period_end
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (period_end) begin
            if (blink_cnt >= blink_half) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        blink_gate = ~blink_mask | {NUM_LEDS{blink_phase}};
    end
`else
    always_comb begin
        blink_gate = '1;
    end
`endif

    always_comb begin
        pwm_on = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            pwm_on[i] = pwm_cnt < duty_act[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt  <= '0;
            duty_act <= {NUM_LEDS{DUTY_RESET}};
            led_out  <= '0;
        end else if (!enable) begin
            pwm_cnt  <= '0;
            duty_act <= duty_reg;
            led_out  <= '0;
        end else begin
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (period_end) begin
                duty_act <= duty_reg;
            end
            led_out <= led_in & pwm_on & blink_gate;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata[CTRL_ENABLE_BIT]  = enable;
            ADDR_PRESCALE: readdata[PRESCALE_W-1:0]   = prescale;
            ADDR_DUTY:     readdata[DUTY_BITS-1:0]    = duty_reg;
`ifdef WIPHASE_LED_BLINK_EN
            ADDR_BLINK: begin
                readdata[BLINK_W-1:0]                = blink_half;
                readdata[BLINK_MASK_LSB +: NUM_LEDS] = blink_mask;
            end
`endif
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_wiphase_led_pwm.sv
// Self-checking bench for wiphase_led_pwm (honours WIPHASE_LED_BLINK_EN).
module tb_wiphase_led_pwm;
    import wiphase_led_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  led_in = 4'hF;
    logic [3:0]  led_out;

    wiphase_led_pwm #(
        .NUM_LEDS       (4),
        .PRESCALE_RESET (16'd49),
        .DUTY_RESET     (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     duty;
        logic [3:0]      led_in;
        logic [3:0][8:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_t;

    vec_t        vt[4];
    rd_t         rt[4];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    int unsigned hi[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive_wr(a, d);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic count_high(input int unsigned n);
        for (int j = 0; j < 4; j++) hi[j] = 0;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) if (led_out[j]) hi[j]++;
        end
    endtask

    task automatic push4(input int unsigned e0, input int unsigned e1,
                         input int unsigned e2, input int unsigned e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    task automatic sb_check(input string name);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] e;
            e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
            check($sformatf("%s_led%0d", name, j), hi[j], e);
        end
    endtask

    initial begin
        logic        prev;
        logic        found;
        logic        s_a;
        logic        s_b;
        int unsigned first_fall;
        int unsigned cnt;

        vt[0] = '{32'h0040_8000, 4'hF, {9'd0,  9'd64,  9'd128, 9'd0}};
        vt[1] = '{32'h01FF_1080, 4'hF, {9'd1,  9'd255, 9'd16,  9'd128}};
        vt[2] = '{32'hFFFF_FFFF, 4'h5, {9'd0,  9'd255, 9'd0,   9'd255}};
        vt[3] = '{32'h20C0_0102, 4'hE, {9'd32, 9'd192, 9'd1,   9'd0}};
        rt[0] = '{ADDR_CTRL,     32'h0000_0001};
        rt[1] = '{ADDR_PRESCALE, 32'd49};
        rt[2] = '{ADDR_DUTY,     32'hFFFF_FFFF};
        rt[3] = '{ADDR_BLINK,    32'h0000_0000};

        // Reset state and register defaults
        repeat (3) @(negedge clk);
        check("reset_led_out", {28'd0, led_out}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) rd_check($sformatf("reset_rd%0d", i), rt[i].addr, rt[i].exp);

        // Default brightness: 255 of 256 ticks at 50 clks per tick
        push4(12750, 12750, 12750, 12750);
        repeat (5) @(negedge clk);
        count_high(12800);
        sb_check("default");

        wr(ADDR_CTRL, 32'hFFFF_FFFF);
        rd_check("ctrl_unused_bits", ADDR_CTRL, 32'h1);

        // Duty table at PRESCALE=0
        wr(ADDR_PRESCALE, 32'h0);
        rd_check("prescale_rd", ADDR_PRESCALE, 32'h0);
        for (int v = 0; v < 4; v++) begin
            led_in = vt[v].led_in;
            wr(ADDR_DUTY, vt[v].duty);
            push4(vt[v].exp[0], vt[v].exp[1], vt[v].exp[2], vt[v].exp[3]);
            repeat (600) @(negedge clk);
            count_high(256);
            sb_check($sformatf("vec%0d", v));
            rd_check($sformatf("vec%0d_duty_rd", v), ADDR_DUTY, vt[v].duty);
        end

        // Mid-period DUTY write: old duty finishes the period, new one after wrap
        led_in = 4'hF;
        wr(ADDR_DUTY, 32'h0000_0080);
        repeat (600) @(negedge clk);
        prev  = led_out[0];
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (!prev && led_out[0]) found = 1'b1;
            prev = led_out[0];
        end
        check("mid_sync", {31'd0, found}, 32'd1);
        push4(128, 32, 0, 0);
        for (int j = 0; j < 4; j++) hi[j] = 0;
        hi[0] = 1;
        s_a = 1'b0;
        s_b = 1'b1;
        for (int k = 1; k < 512; k++) begin
            @(negedge clk);
            if (k == 11) idle_bus();
            if (led_out[0]) begin
                if (k < 256) hi[0]++;
                else hi[1]++;
            end
            if (k == 256) s_a = led_out[0];
            if (k == 288) s_b = led_out[0];
            if (k == 10) drive_wr(ADDR_DUTY, 32'h0000_0020);
        end
        sb_check("mid_duty");
        check("mid_first_new", {31'd0, s_a}, 32'd1);
        check("mid_new_end", {31'd0, s_b}, 32'd0);

        // Blink on LED0, half_period 1
        wr(ADDR_DUTY, 32'hFFFF_FFFF);
        wr(ADDR_BLINK, 32'h0001_0001);
`ifdef WIPHASE_LED_BLINK_EN
        rd_check("blink_rd", ADDR_BLINK, 32'h0001_0001);
        push4(510, 1020, 1020, 1020);
`else
        rd_check("blink_rd", ADDR_BLINK, 32'h0);
        push4(1020, 1020, 1020, 1020);
`endif
        repeat (600) @(negedge clk);
        count_high(1024);
        sb_check("blink");
        wr(ADDR_BLINK, 32'h0);

        // Disable mid-period, then re-enable from zeroed counters
        wr(ADDR_DUTY, 32'h0040_8000);
        repeat (600) @(negedge clk);
        wr(ADDR_CTRL, 32'h0);
        push4(0, 0, 0, 0);
        count_high(20);
        sb_check("disabled");
        rd_check("ctrl_off_rd", ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h1);
        check("reenable_s0", {28'd0, led_out}, 32'd0);
        push4(0, 128, 64, 0);
        for (int j = 0; j < 4; j++) hi[j] = 0;
        s_a = 1'b0;
        s_b = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) if (led_out[j]) hi[j]++;
            if (k == 1)   s_a = led_out[1];
            if (k == 129) s_b = led_out[1];
        end
        sb_check("reenable");
        check("reenable_first", {31'd0, s_a}, 32'd1);
        check("reenable_fall", {31'd0, s_b}, 32'd0);

        // Reset mid-period, then PRESCALE lowered 1000 -> 5 at pre_cnt=600
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midreset_led_out", {28'd0, led_out}, 32'd0);
        reset = 1'b0;
        rd_check("midreset_duty_rd", ADDR_DUTY, 32'hFFFF_FFFF);
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_PRESCALE, 32'd1000);
        wr(ADDR_DUTY, 32'h0000_0001);
        wr(ADDR_CTRL, 32'h1);
        first_fall = 0;
        cnt = 0;
        s_a = 1'b0;
        s_b = 1'b1;
        for (int unsigned k = 1; k <= 2200; k++) begin
            @(negedge clk);
            if (k == 600) idle_bus();
            if (led_out[0]) cnt++;
            else if (first_fall == 0) first_fall = k;
            if (k == 2137) s_a = led_out[0];
            if (k == 2138) s_b = led_out[0];
            if (k == 599) drive_wr(ADDR_PRESCALE, 32'd5);
        end
        check("presc_first_tick", first_fall, 32'd602);
        check("presc_high_total", cnt, 32'd607);
        check("presc_wrap_last", {31'd0, s_a}, 32'd1);
        check("presc_wrap_end", {31'd0, s_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
